// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: datapath hazard inputs plus pipeline-register controls and statistics.
// The master modport is the controller side, and the slave modport is the datapath side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic [4:0]       if_id_rn;
  logic [4:0]       if_id_rm;
  logic             if_id_uses_rn;
  logic             if_id_uses_rm;
  logic             branch_taken;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pc_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  id_ex_memread, id_ex_rd, if_id_rn, if_id_rm,
           if_id_uses_rn, if_id_uses_rm, branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           pc_sel, stall_cycles, flush_count
  );

  modport slave (
    output id_ex_memread, id_ex_rd, if_id_rn, if_id_rm,
           if_id_uses_rn, if_id_uses_rm, branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           pc_sel, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline.
// Its control outputs are combinational from the inputs and the state; its counters saturate.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.master bus
);
  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [2:0]       STALL_INIT = 3'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [2:0]       cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hz;
  logic             stall_req;
  logic             do_stall;

  // Load-use detection; XZR (register 31) never creates a dependency.
  always_comb begin
    hz = bus.id_ex_memread && (bus.id_ex_rd != 5'd31) &&
         ((bus.if_id_uses_rn && (bus.id_ex_rd == bus.if_id_rn)) ||
          (bus.if_id_uses_rm && (bus.id_ex_rd == bus.if_id_rm)));
    case (state)
      RUN:     stall_req = hz;
      STALL:   stall_req = 1'b1;
      default: stall_req = 1'b0;
    endcase
    do_stall = stall_req && !bus.branch_taken;
  end

  // Pipeline register controls with the priority reset > branch > stall > idle.
  always_comb begin
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.pc_sel       = 1'b0;
    if (rst) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (bus.branch_taken) begin
      bus.pc_sel       = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (do_stall) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_flush  = 1'b1;
    end else begin
      bus.pc_en        = 1'b1;
      bus.if_id_en     = 1'b1;
    end
  end

  // Stall sequencing and the saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 3'd0;
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      case (state)
        RUN: begin
          if (!bus.branch_taken && hz && (LOAD_STALL > 1)) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end
        end
        STALL: begin
          if (bus.branch_taken || (cnt == 3'd1)) begin
            state <= RUN;
            cnt   <= 3'd0;
          end else begin
            cnt   <= cnt - 3'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 3'd0;
        end
      endcase
      if (do_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (bus.branch_taken && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with three instances: LOAD_STALL=1, LOAD_STALL=3, and CNT_W=4.
// The control outputs are packed as {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, pc_sel}.
module tb_pipeline_hazard_ctrl;
  localparam logic [5:0] O_RESET = 6'b001110;
  localparam logic [5:0] O_IDLE  = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [18:0] vec;
  logic [5:0]  o1, o3, o4;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) b1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) b3 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  b4 ();

  pipeline_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  pipeline_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(b3.master));
  pipeline_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(b4.master));

  // The vector is {memread, rd, rn, rm, uses_rn, uses_rm, branch_taken}.
  assign {b1.id_ex_memread, b1.id_ex_rd, b1.if_id_rn, b1.if_id_rm, b1.if_id_uses_rn,
          b1.if_id_uses_rm, b1.branch_taken} = (sel == 2'd0) ? vec : 19'd0;
  assign {b3.id_ex_memread, b3.id_ex_rd, b3.if_id_rn, b3.if_id_rm, b3.if_id_uses_rn,
          b3.if_id_uses_rm, b3.branch_taken} = (sel == 2'd1) ? vec : 19'd0;
  assign {b4.id_ex_memread, b4.id_ex_rd, b4.if_id_rn, b4.if_id_rm, b4.if_id_uses_rn,
          b4.if_id_uses_rm, b4.branch_taken} = (sel == 2'd2) ? vec : 19'd0;

  assign o1 = {b1.pc_en, b1.if_id_en, b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush, b1.pc_sel};
  assign o3 = {b3.pc_en, b3.if_id_en, b3.if_id_flush, b3.id_ex_flush, b3.ex_mem_flush, b3.pc_sel};
  assign o4 = {b4.pc_en, b4.if_id_en, b4.if_id_flush, b4.id_ex_flush, b4.ex_mem_flush, b4.pc_sel};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic setv(input logic [1:0] s, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm,
                      input logic urn, input logic urm, input logic br);
    sel = s;
    vec = {mr, rd, rn, rm, urn, urm, br};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sel = 2'd0;
    vec = 19'd0;
    // Reset is held for two cycles.
    cyc();
    chk_eq("reset_out_1", 32'(o1), 32'(O_RESET));
    chk_eq("reset_out_3", 32'(o3), 32'(O_RESET));
    cyc();
    chk_eq("reset_out_4", 32'(o4), 32'(O_RESET));
    rst = 1'b0;
    #1;
    chk_eq("post_reset_idle", 32'(o1), 32'(O_IDLE));
    cyc();
    chk_eq("post_reset_stall_cnt", 32'(b1.stall_cycles), 32'd0);
    chk_eq("post_reset_flush_cnt", 32'(b1.flush_count), 32'd0);

    // A single-cycle load-use stall.
    setv(2'd0, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    chk_eq("lu1_stall", 32'(o1), 32'(O_STALL));
    cyc();
    setv(2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("lu1_idle", 32'(o1), 32'(O_IDLE));
    chk_eq("lu1_stall_cnt", 32'(b1.stall_cycles), 32'd1);

    // These register matches must not cause a stall.
    setv(2'd0, 1'b1, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0);
    chk_eq("xzr_no_stall", 32'(o1), 32'(O_IDLE));
    cyc();
    setv(2'd0, 1'b1, 5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    chk_eq("rm_unused_no_stall", 32'(o1), 32'(O_IDLE));
    cyc();
    setv(2'd0, 1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0);
    chk_eq("no_memread_no_stall", 32'(o1), 32'(O_IDLE));
    cyc();
    setv(2'd0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    chk_eq("rm_match_stall", 32'(o1), 32'(O_STALL));
    cyc();
    setv(2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("rm_match_cnt", 32'(b1.stall_cycles), 32'd2);

    // A three-cycle stall when LOAD_STALL is 3.
    setv(2'd1, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    chk_eq("ls3_stall_c1", 32'(o3), 32'(O_STALL));
    cyc();
    setv(2'd1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("ls3_stall_c2", 32'(o3), 32'(O_STALL));
    cyc();
    chk_eq("ls3_stall_c3", 32'(o3), 32'(O_STALL));
    cyc();
    chk_eq("ls3_run_c4", 32'(o3), 32'(O_IDLE));
    chk_eq("ls3_stall_cnt", 32'(b3.stall_cycles), 32'd3);

    // A taken branch aborts the stall in its second cycle.
    cyc();
    setv(2'd1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    chk_eq("abort_stall_c1", 32'(o3), 32'(O_STALL));
    cyc();
    setv(2'd1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk_eq("abort_flush", 32'(o3), 32'(O_FLUSH));
    cyc();
    setv(2'd1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("abort_back_run", 32'(o3), 32'(O_IDLE));
    chk_eq("abort_stall_cnt", 32'(b3.stall_cycles), 32'd4);
    chk_eq("abort_flush_cnt", 32'(b3.flush_count), 32'd1);

    // When a hazard and a taken branch coincide, only the flush happens.
    cyc();
    setv(2'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    chk_eq("simul_flush", 32'(o1), 32'(O_FLUSH));
    cyc();
    setv(2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("simul_idle", 32'(o1), 32'(O_IDLE));
    chk_eq("simul_stall_cnt", 32'(b1.stall_cycles), 32'd2);
    chk_eq("simul_flush_cnt", 32'(b1.flush_count), 32'd1);

    // The 4-bit flush counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      setv(2'd2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      if (i == 15) chk_eq("sat_at_15", 32'(b4.flush_count), 32'd15);
      cyc();
    end
    setv(2'd2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("sat_hold_15", 32'(b4.flush_count), 32'd15);
    chk_eq("sat_stall_cnt", 32'(b4.stall_cycles), 32'd0);

    // A reset during a stall leaves no stall behind.
    cyc();
    setv(2'd1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    chk_eq("midrst_stall", 32'(o3), 32'(O_STALL));
    cyc();
    setv(2'd1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_eq("midrst_reset_out", 32'(o3), 32'(O_RESET));
    cyc();
    rst = 1'b0;
    #1;
    chk_eq("midrst_idle", 32'(o3), 32'(O_IDLE));
    chk_eq("midrst_stall_cnt", 32'(b3.stall_cycles), 32'd0);
    chk_eq("midrst_flush_cnt", 32'(b3.flush_count), 32'd0);
    cyc();
    chk_eq("midrst_still_idle", 32'(o3), 32'(O_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
